// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: control encodings, bus widths and FSM states.
package dmem_responder_pkg;

   // Control-level encodings
   localparam logic RstEnable   = 1'b1;
   localparam logic ChipEnable  = 1'b1;
   localparam logic WriteEnable = 1'b1;

   // Data bus geometry
   localparam int unsigned RegBus   = 32;
   localparam int unsigned LaneW    = 8;
   localparam int unsigned NumLanes = RegBus / LaneW;

   localparam logic [RegBus-1:0] ZeroWord = '0;

   // Default word-index width (2**17 words of 32 bits)
   localparam int unsigned DataMemNumLog2 = 17;

   // Responder FSM states
   typedef enum logic {
      IDLE  = 1'b0,
      RDONE = 1'b1
   } dmem_state_e;

endpackage : dmem_responder_pkg

// File: rtl/dmem_byte_bank.sv
// One byte lane of the data RAM: synchronous write, registered read that holds between reads.
module dmem_byte_bank
   import dmem_responder_pkg::*;
#(
   parameter int unsigned      ADDR_W  = DataMemNumLog2,
   parameter logic [LaneW-1:0] RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LaneW-1:0]  wdata_i,
   output logic [LaneW-1:0]  rdata_o
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   // Array contents are never touched by reset
   logic [LaneW-1:0] mem_array [Depth];

   logic [LaneW-1:0] rdata_q;
   logic [LaneW-1:0] rdata_d;

   // Byte write on the clock edge when this lane is enabled
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_array[addr_i] <= wdata_i;
      end
   end

   // Read register loads only when a read is issued, otherwise holds the last word byte
   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         rdata_d = mem_array[addr_i];
      end
   end

   // Read register with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         rdata_q <= RST_VAL;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule : dmem_byte_bank

// File: rtl/dmem_responder.sv
// Memory-stage load/store responder: byte-enabled single-cycle stores, one-stall word loads.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W    = DataMemNumLog2,
   parameter string       INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_i,
   input  logic              we_i,
   input  logic [31:0]       addr_i,
   input  logic [3:0]        sel_i,
   input  logic [RegBus-1:0] data_i,
   output logic [RegBus-1:0] data_o,
   output logic              stallreq_o
);

   localparam int unsigned IdxLsb = 2;
   localparam int unsigned IdxMsb = ADDR_W + 1;

   // Image preload belongs to the RAM macro flow; the name is carried for integration only
   localparam string unused_init_file = INIT_FILE;

   dmem_state_e state_q;
   dmem_state_e state_d;

   logic [ADDR_W-1:0]   word_idx_c;
   logic [NumLanes-1:0] lane_we_c;
   logic                rd_en_c;

   // Byte offset and bits above the array alias away
   logic [31-ADDR_W:0]  unused_addr_bits;

   assign word_idx_c       = addr_i[IdxMsb:IdxLsb];
   assign unused_addr_bits = {addr_i[31:IdxMsb+1], addr_i[IdxLsb-1:0]};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a load moves to RDONE, RDONE always returns to IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if ((ce_i == ChipEnable) && (we_i != WriteEnable)) begin
               state_d = RDONE;
            end
         end
         RDONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: lane write enables, read issue and stall, all gated to IDLE
   always_comb begin
      lane_we_c  = '0;
      rd_en_c    = 1'b0;
      stallreq_o = 1'b0;
      if ((state_q == IDLE) && (ce_i == ChipEnable)) begin
         if (we_i == WriteEnable) begin
            lane_we_c = sel_i;
         end else begin
            rd_en_c    = 1'b1;
            stallreq_o = 1'b1;
         end
      end
   end

   // Four byte lanes; lane k carries data[8k+7:8k]
   for (genvar k = 0; k < NumLanes; k++) begin : g_lane
      dmem_byte_bank #(
         .ADDR_W  (ADDR_W),
         .RST_VAL (ZeroWord[k*LaneW +: LaneW])
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .we_i    (lane_we_c[k]),
         .re_i    (rd_en_c),
         .addr_i  (word_idx_c),
         .wdata_i (data_i[k*LaneW +: LaneW]),
         .rdata_o (data_o[k*LaneW +: LaneW])
      );
   end

endmodule : dmem_responder

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the memory-stage load/store bus: accepts chip-enable, write-enable, word address, 4-bit byte-lane select and write data. It performs byte-enabled writes in one cycle and word reads through a synchronous array. A stall request holds the pipeline until read data is valid. It sits between the memory stage and the on-chip data RAM, and its stall output feeds the pipeline control block.

## Interface
- ADDR_W, 17, word-index width; depth = 2**ADDR_W words of 32 bits
- INIT_FILE, "", optional hex image loaded at elaboration; empty means contents are undefined
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high
- ce_i  input  1  chip enable from memory stage (1 = access requested)
- we_i  input  1  1 = store, 0 = load; meaningful only when ce_i=1
- addr_i  input  32  byte address; word index = addr_i[ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 ignored (aliasing)
- sel_i  input  4  byte-lane enables, big-endian: sel_i[3] -> data[31:24] ... sel_i[0] -> data[7:0]
- data_i  input  32  store data, already lane-replicated by the memory stage
- data_o  output  32  full read word; the memory stage extracts lanes
- stallreq_o  output  1  1 = hold pipeline, read result not yet valid

## Operation
- FSM states: IDLE, RDONE.
- IDLE, ce_i=0: no array access; stallreq_o=0; stay IDLE.
- IDLE, ce_i=1, we_i=1 (store): on the clock edge, each lane with sel_i[k]=1 is written from data_i; other lanes are unchanged. sel_i=0000 writes nothing. stallreq_o=0; stay IDLE.
- IDLE, ce_i=1, we_i=0 (load): array read issued; stallreq_o=1 combinationally in the same cycle. Next state RDONE; data_o captures the full word.
- RDONE: stallreq_o=0 and data_o holds the read word. The held request is not reissued. Unconditionally return to IDLE, with no array access this cycle.
- data_o updates only on load completion and otherwise holds its last value.
- Reads ignore sel_i and always return all 4 bytes.
- Memory contents are never cleared by rst.

## Timing
- Reset values: state=IDLE, data_o=32'h0, stallreq_o=0. Assertion is asynchronous; the first state change happens on the first clk edge after deassertion.
- Load latency: request in cycle N, data_o valid in cycle N+1. Each load stalls exactly one cycle.
- Store latency: 0 stall cycles. The array is updated at the end of cycle N. A load to the same word in cycle N+1 returns the new data, since there is no forwarding path and none is needed.
- Back-to-back loads: N load A (stall), N+1 data A, N+2 load B (stall), N+3 data B.
- Load in N followed by store in N+2: the store is handled normally in IDLE.
- Reset during RDONE: state returns to IDLE and data_o=0. The pending result is discarded; the pipeline is reset as well.
- stallreq_o depends combinationally on state, ce_i and we_i only, and never on data.

## Structure
- The shared defines file holds: RstEnable (1'b1), ChipEnable, WriteEnable, ZeroWord, RegBus, DataMemNumLog2 (used as the ADDR_W default), and the IDLE/RDONE state encodings.
- One sub-module, dmem_byte_bank: an 8-bit-wide, 2**ADDR_W-deep synchronous RAM with write enable and registered read. It is instantiated four times, lane k enabled by sel_i[k]&we_i&ce_i while in IDLE.
- The top level holds the FSM, lane-enable decode, word-index slicing and data_o assembly.

## Test plan
- Reset: assert rst mid-load (state RDONE) -> data_o=0, stallreq_o=0 immediately. After release, an idle cycle keeps stallreq_o=0.
- Word store/load: store addr 0x0000_0100, sel 1111, data 0xDEADBEEF. Then load 0x100 -> stallreq_o=1 for one cycle, then data_o=0xDEADBEEF with stallreq_o=0.
- Byte-lane store: init word 0x100 = 0x11223344. Store sel 0100, data 0xAAAAAAAA. Then load -> 0x11AA3344.
- Null and half stores: sel 0000 store leaves 0x11AA3344 unchanged. sel 0011, data 0x5566_5566 -> 0x11AA5566.
- Back-to-back loads of 0x100 and 0x104 -> stall pattern 1,0,1,0. Data appears in cycles N+1 and N+3 with the correct words.
- Aliasing and idle: load 0x100 + (4<<ADDR_W) -> same word as 0x100. ce_i=0 for 3 cycles -> no stall and data_o unchanged.
